// File: rtl/dual_issue_fetch_buffer_pkg.sv
// Shared definitions for the dual-issue fetch buffer.
// Contents: MIPS-style opcode/funct constants, the NOP encoding, and dest_reg(),
// which returns the architectural register an instruction writes (0 = none).
package dual_issue_fetch_buffer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Register written by instr; 0 means "writes nothing" (writes to $0 are discarded anyway).
  function automatic logic [4:0] dest_reg(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    if (op == OP_RTYPE) begin
      dest_reg = (instr[5:0] == FN_JR) ? 5'd0 : instr[15:11];
    end else if (op == OP_JAL) begin
      dest_reg = 5'd31;
    end else if (op == OP_SW || op == OP_BEQ || op == OP_BNE || op == OP_J) begin
      dest_reg = 5'd0;
    end else begin
      dest_reg = instr[20:16];
    end
  endfunction

endpackage

// File: rtl/dual_issue_fetch_buffer_issue_pair_check.sv
// Combinational pairing check for the two head queue entries.
// Ports:
//   instr_a    in  32  older instruction (slot1 candidate)
//   instr_b    in  32  younger instruction (slot2 candidate)
//   dual_ok    out 1   both may issue together
//   split_ctrl out 1   instr_a is a control transfer
//   split_mem  out 1   both are memory ops (single data port)
//   split_raw  out 1   instr_b reads instr_a's destination
//   split_waw  out 1   both write the same destination
module issue_pair_check
  import dual_issue_fetch_buffer_pkg::*;
(
  input  logic [31:0] instr_a,
  input  logic [31:0] instr_b,
  output logic        dual_ok,
  output logic        split_ctrl,
  output logic        split_mem,
  output logic        split_raw,
  output logic        split_waw
);

  logic [5:0] op_a;
  logic [5:0] op_b;
  logic [4:0] dest_a;
  logic       mem_a;
  logic       mem_b;
  logic       unused_bits;

  assign op_a   = instr_a[31:26];
  assign op_b   = instr_b[31:26];
  assign dest_a = dest_reg(instr_a);
  assign mem_a  = (op_a == OP_LW) || (op_a == OP_SW);
  assign mem_b  = (op_b == OP_LW) || (op_b == OP_SW);

  assign split_ctrl = (op_a == OP_BEQ) || (op_a == OP_BNE) || (op_a == OP_J) ||
                      (op_a == OP_JAL) || ((op_a == OP_RTYPE) && (instr_a[5:0] == FN_JR));
  assign split_mem  = mem_a && mem_b;
  // rs and rt of instr_b are compared regardless of whether its format reads them.
  assign split_raw  = (dest_a != 5'd0) &&
                      ((dest_a == instr_b[25:21]) || (dest_a == instr_b[20:16]));
  assign split_waw  = (dest_a != 5'd0) && (dest_a == dest_reg(instr_b));
  assign dual_ok    = !(split_ctrl || split_mem || split_raw || split_waw);

  // Shamt/imm bits and instr_a's rs do not influence pairing.
  assign unused_bits = ^{instr_a[25:21], instr_a[10:6], instr_b[10:6]};

endmodule

// File: rtl/dual_issue_fetch_buffer.sv
// Instruction queue plus issue register between IMEM fetch and dual-issue decode.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   fetch_valid[1:0]         instr0/instr1 valid (2'b10 is illegal and is ignored)
//   fetch_instr0/1, pc0/1    fetched instructions (0 older) and their PCs
//   fetch_ready              at least two free entries; writes accepted only when high
//   stall                    hold issue register, no pop (writes still accepted)
//   flush                    discard queue and issue register (beats stall and writes)
//   instruction1/2, pc1/2    issue register slots (slot1 older)
//   valid1/2                 slot holds a real instruction
//   count                    occupied queue entries
//   pair_split               last issue was single because a pairing rule fired
module dual_issue_fetch_buffer
  import dual_issue_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    fetch_valid,
  input  logic [31:0]   fetch_instr0,
  input  logic [31:0]   fetch_instr1,
  input  logic [31:0]   fetch_pc0,
  input  logic [31:0]   fetch_pc1,
  output logic          fetch_ready,
  input  logic          stall,
  input  logic          flush,
  output logic [31:0]   instruction1,
  output logic [31:0]   instruction2,
  output logic [31:0]   pc1,
  output logic [31:0]   pc2,
  output logic          valid1,
  output logic          valid2,
  output logic [AW:0]   count,
  output logic          pair_split
);

  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_nx, wr_ptr_nx;
  logic [AW:0]   count_q, count_d, wr_cnt, pop_cnt;
  logic [31:0]   instr1_q, instr1_d, instr2_q, instr2_d;
  logic [31:0]   pc1_q, pc1_d, pc2_q, pc2_d;
  logic          valid1_q, valid1_d, valid2_q, valid2_d;
  logic          split_q, split_d;

  logic [31:0] head_instr, next_instr, head_pc, next_pc;
  logic        dual_ok, split_ctrl, split_mem, split_raw, split_waw;
  logic        unused_reasons;

  assign rd_ptr_nx  = rd_ptr_q + AW'(1);
  assign wr_ptr_nx  = wr_ptr_q + AW'(1);
  assign head_instr = instr_mem[rd_ptr_q];
  assign next_instr = instr_mem[rd_ptr_nx];
  assign head_pc    = pc_mem[rd_ptr_q];
  assign next_pc    = pc_mem[rd_ptr_nx];
  assign fetch_ready = (count_q <= READY_MAX);

  issue_pair_check u_pair_check (
    .instr_a    (head_instr),
    .instr_b    (next_instr),
    .dual_ok    (dual_ok),
    .split_ctrl (split_ctrl),
    .split_mem  (split_mem),
    .split_raw  (split_raw),
    .split_waw  (split_waw)
  );

  // Individual reasons are informational only; dual_ok already combines them.
  assign unused_reasons = split_ctrl ^ split_mem ^ split_raw ^ split_waw;

  always_comb begin
    wr_cnt   = '0;
    pop_cnt  = '0;
    instr1_d = instr1_q;
    instr2_d = instr2_q;
    pc1_d    = pc1_q;
    pc2_d    = pc2_q;
    valid1_d = valid1_q;
    valid2_d = valid2_q;
    split_d  = split_q;

    if (fetch_ready && !flush) begin
      case (fetch_valid)
        2'b01:   wr_cnt = (AW+1)'(1);
        2'b11:   wr_cnt = (AW+1)'(2);
        default: wr_cnt = '0;
      endcase
    end

    if (!stall) begin
      // Pop decision only looks at count_q, so entries written this edge wait a cycle.
      if (count_q == '0) begin
        pop_cnt = '0;
      end else if ((count_q >= (AW+1)'(2)) && dual_ok) begin
        pop_cnt = (AW+1)'(2);
      end else begin
        pop_cnt = (AW+1)'(1);
      end
      split_d  = (count_q >= (AW+1)'(2)) && !dual_ok;
      valid1_d = (pop_cnt != '0);
      valid2_d = (pop_cnt == (AW+1)'(2));
      instr1_d = valid1_d ? head_instr : NOP;
      pc1_d    = valid1_d ? head_pc    : 32'h0;
      instr2_d = valid2_d ? next_instr : NOP;
      pc2_d    = valid2_d ? next_pc    : 32'h0;
    end

    rd_ptr_d = rd_ptr_q + pop_cnt[AW-1:0];
    wr_ptr_d = wr_ptr_q + wr_cnt[AW-1:0];
    count_d  = count_q + wr_cnt - pop_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      instr1_q <= NOP;
      instr2_q <= NOP;
      pc1_q    <= '0;
      pc2_q    <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      split_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      instr1_q <= instr1_d;
      instr2_q <= instr2_d;
      pc1_q    <= pc1_d;
      pc2_q    <= pc2_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
      split_q  <= split_d;
    end
  end

  // Storage has no reset; validity is tracked purely by pointers/count.
  always_ff @(posedge clk) begin
    if (!rst && wr_cnt != '0) begin
      instr_mem[wr_ptr_q] <= fetch_instr0;
      pc_mem[wr_ptr_q]    <= fetch_pc0;
      if (wr_cnt == (AW+1)'(2)) begin
        instr_mem[wr_ptr_nx] <= fetch_instr1;
        pc_mem[wr_ptr_nx]    <= fetch_pc1;
      end
    end
  end

  assign instruction1 = instr1_q;
  assign instruction2 = instr2_q;
  assign pc1          = pc1_q;
  assign pc2          = pc2_q;
  assign valid1       = valid1_q;
  assign valid2       = valid2_q;
  assign count        = count_q;
  assign pair_split   = split_q;

endmodule
